// File: rtl/ipg_req_sched_if.sv
// rtl/ipg_req_sched_if.sv - request/response chunk bundle between ipg_req_sched and the PHY IPG path
interface ipg_req_sched_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic [DATA_WIDTH-1:0] ipg_req_chunk;
    logic                  valid_req;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] ipg_rresp_chunk;
    logic                  rresp_valid;

    modport master (
        output ipg_req_chunk,
        output valid_req,
        input  req_ready,
        input  ipg_rresp_chunk,
        input  rresp_valid
    );

    modport slave (
        input  ipg_req_chunk,
        input  valid_req,
        output req_ready,
        output ipg_rresp_chunk,
        output rresp_valid
    );
endinterface

// File: rtl/ipg_req_sched.sv
// rtl/ipg_req_sched.sv - tagged IPG request generator with response matching, latency and timeout tracking
module ipg_req_sched #(
    parameter int         DATA_WIDTH     = 64,
    parameter int         CHANNELS       = 4,
    parameter int         TAG_WIDTH      = 4,
    parameter int         TS_WIDTH       = 32,
    parameter int         START_DELAY    = 256,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] REQ_OPCODE     = 8'h52,
    parameter logic [7:0] RESP_OPCODE    = 8'h41
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [15:0]         interval,
    input  logic [31:0]         req_count,
    ipg_req_sched_if.master     bus,
    output logic                busy,
    output logic                done,
    output logic [31:0]         stat_sent,
    output logic [31:0]         stat_rcvd,
    output logic [31:0]         stat_timeout,
    output logic [31:0]         stat_unmatched,
    output logic [TS_WIDTH-1:0] stat_lat_last,
    output logic [TS_WIDTH-1:0] stat_lat_max
);
    localparam int DEPTH = 2 ** TAG_WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DELAY = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [31:0]         DELAY_LOAD  = (START_DELAY > 0) ? 32'(START_DELAY - 1) : 32'd0;
    localparam logic [7:0]          CHAN_LAST   = 8'(CHANNELS - 1);
    localparam logic [TS_WIDTH-1:0] TIMEOUT_AGE = TS_WIDTH'(TIMEOUT_CYCLES);

    logic [2:0]            state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [31:0]           run_q, run_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [7:0]            chan_q, chan_d;
    logic [TS_WIDTH-1:0]   issue_ts_q, issue_ts_d;
    logic [DATA_WIDTH-1:0] chunk_q, chunk_d;

    logic [TS_WIDTH-1:0]   ts_q;
    logic [TAG_WIDTH-1:0]  scan_q;
    logic [DEPTH-1:0]      busy_q;
    logic [TS_WIDTH-1:0]   ent_ts_q [DEPTH];
    logic [31:0]           sent_q, rcvd_q, timeout_q, unm_q;
    logic [TS_WIDTH-1:0]   lat_last_q, lat_max_q;

    logic [TS_WIDTH-1:0]   ts_next;
    logic [31:0]           intv_load;
    logic [DATA_WIDTH-1:0] new_chunk;
    logic                  hs;
    logic [7:0]            resp_tag_raw;
    logic [TAG_WIDTH-1:0]  resp_tag;
    logic                  resp_hit, resp_in_range, resp_match, resp_unm;
    logic [TS_WIDTH-1:0]   resp_lat, scan_age;
    logic                  to_hit;
    logic                  unused_resp_bits;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign ts_next   = ts_q + TS_WIDTH'(1);
    assign intv_load = (interval == 16'd0) ? 32'd0 : {16'd0, interval} - 32'd1;
    assign hs        = (state_q == S_ISSUE) && bus.req_ready;

    // The chunk timestamp is the value ts_q holds while the chunk is first presented.
    always_comb begin
        new_chunk                  = '0;
        new_chunk[7:0]             = REQ_OPCODE;
        new_chunk[8 +: TAG_WIDTH]  = tag_q;
        new_chunk[23:16]           = chan_q;
        new_chunk[63:32]           = 32'(ts_next);
    end

    assign resp_tag_raw     = bus.ipg_rresp_chunk[15:8];
    assign resp_tag         = resp_tag_raw[TAG_WIDTH-1:0];
    assign resp_hit         = bus.rresp_valid && (bus.ipg_rresp_chunk[7:0] == RESP_OPCODE);
    assign resp_in_range    = ({24'd0, resp_tag_raw} < 32'(DEPTH));
    assign resp_match       = resp_hit && resp_in_range && busy_q[resp_tag];
    assign resp_unm         = resp_hit && !resp_match;
    assign resp_lat         = ts_q - ent_ts_q[resp_tag];
    assign scan_age         = ts_q - ent_ts_q[scan_q];
    // A response freeing the scanned entry in the same cycle takes precedence over its timeout.
    assign to_hit           = busy_q[scan_q] && (scan_age >= TIMEOUT_AGE) &&
                              !(resp_match && (resp_tag == scan_q));
    assign unused_resp_bits = ^bus.ipg_rresp_chunk[DATA_WIDTH-1:16];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_d      = run_q;
        tag_d      = tag_q;
        chan_d     = chan_q;
        issue_ts_d = issue_ts_q;
        chunk_d    = chunk_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_DELAY;
                    cnt_d   = DELAY_LOAD;
                    run_d   = 32'd0;
                end
            end
            S_DELAY: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 32'd0) begin
                    state_d = S_WAIT;
                    cnt_d   = intv_load;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (!busy_q[tag_q]) begin
                    state_d    = S_ISSUE;
                    issue_ts_d = ts_next;
                    chunk_d    = new_chunk;
                end
            end
            S_ISSUE: begin
                if (bus.req_ready) begin
                    tag_d  = tag_q + TAG_WIDTH'(1);
                    chan_d = (chan_q == CHAN_LAST) ? 8'd0 : chan_q + 8'd1;
                    run_d  = run_q + 32'd1;
                    if ((req_count != 32'd0) && (run_q + 32'd1 == req_count)) begin
                        state_d = S_DONE;
                    end else if (!enable) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = intv_load;
                    end
                end
            end
            S_DONE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            run_q      <= '0;
            tag_q      <= '0;
            chan_q     <= '0;
            issue_ts_q <= '0;
            chunk_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            tag_q      <= tag_d;
            chan_q     <= chan_d;
            issue_ts_q <= issue_ts_d;
            chunk_q    <= chunk_d;
        end
    end

    // Outstanding table, scan pointer, timestamp and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= '0;
            scan_q     <= '0;
            busy_q     <= '0;
            sent_q     <= '0;
            rcvd_q     <= '0;
            timeout_q  <= '0;
            unm_q      <= '0;
            lat_last_q <= '0;
            lat_max_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_ts_q[i] <= '0;
            end
        end else begin
            ts_q   <= ts_next;
            scan_q <= scan_q + TAG_WIDTH'(1);
            if (resp_match) begin
                busy_q[resp_tag] <= 1'b0;
                rcvd_q           <= sat_inc(rcvd_q);
                lat_last_q       <= resp_lat;
                if (resp_lat > lat_max_q) begin
                    lat_max_q <= resp_lat;
                end
            end
            if (resp_unm) begin
                unm_q <= sat_inc(unm_q);
            end
            if (to_hit) begin
                busy_q[scan_q] <= 1'b0;
                timeout_q      <= sat_inc(timeout_q);
            end
            if (hs) begin
                busy_q[tag_q]   <= 1'b1;
                ent_ts_q[tag_q] <= issue_ts_q;
                sent_q          <= sat_inc(sent_q);
            end
        end
    end

    assign bus.valid_req     = (state_q == S_ISSUE);
    assign bus.ipg_req_chunk = chunk_q;
    assign busy              = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done              = (state_q == S_DONE);
    assign stat_sent         = sent_q;
    assign stat_rcvd         = rcvd_q;
    assign stat_timeout      = timeout_q;
    assign stat_unmatched    = unm_q;
    assign stat_lat_last     = lat_last_q;
    assign stat_lat_max      = lat_max_q;
endmodule

// File: tb/tb_ipg_req_sched.sv
// tb/tb_ipg_req_sched.sv - scoreboard bench for ipg_req_sched
module tb_ipg_req_sched;
    localparam int         DW      = 64;
    localparam int         CH      = 3;
    localparam int         TW      = 2;
    localparam int         TSW     = 32;
    localparam int         SD      = 20;
    localparam int         TO      = 100;
    localparam logic [7:0] REQ_OP  = 8'h52;
    localparam logic [7:0] RESP_OP = 8'h41;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic [15:0]    interval = 16'd0;
    logic [31:0]    req_count = 32'd0;
    logic           busy, done;
    logic [31:0]    stat_sent, stat_rcvd, stat_timeout, stat_unmatched;
    logic [TSW-1:0] stat_lat_last, stat_lat_max;

    ipg_req_sched_if #(.DATA_WIDTH(DW)) bif ();

    ipg_req_sched #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .TAG_WIDTH(TW), .TS_WIDTH(TSW),
        .START_DELAY(SD), .TIMEOUT_CYCLES(TO), .REQ_OPCODE(REQ_OP), .RESP_OPCODE(RESP_OP)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .interval(interval), .req_count(req_count),
        .bus(bif), .busy(busy), .done(done),
        .stat_sent(stat_sent), .stat_rcvd(stat_rcvd), .stat_timeout(stat_timeout),
        .stat_unmatched(stat_unmatched), .stat_lat_last(stat_lat_last), .stat_lat_max(stat_lat_max)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] tag; logic [7:0] chan; } exp_t;
    typedef struct packed { logic [31:0] due; logic [63:0] chunk; } rsp_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] tb_ts = 32'd0;
    exp_t        exp_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] hs_q[$];
    logic [7:0]  m_tag = 8'd0;
    logic [7:0]  m_chan = 8'd0;
    bit          echo_en = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] rise_ts = 32'd0;
    logic [63:0] mon_c;
    exp_t        mon_e;
    logic [31:0] en_ts, ts0, t_coll;
    logic [63:0] snap;
    bit          stable;

    // Reference free-running timestamp: counts edges since reset release.
    always @(posedge clk) tb_ts <= rst ? 32'd0 : tb_ts + 32'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_t'{m_tag, m_chan});
            m_tag  = 8'((int'(m_tag) + 1) % (1 << TW));
            m_chan = 8'((int'(m_chan) + 1) % CH);
        end
    endtask

    task automatic send_resp(input logic [7:0] op, input logic [7:0] tagf, input logic [31:0] due);
        rsp_q.push_back(rsp_t'{due, {48'd0, tagf, op}});
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bif.valid_req && !prev_valid) rise_ts = tb_ts;
            prev_valid = bif.valid_req;
            if (bif.valid_req && bif.req_ready) begin
                mon_c = bif.ipg_req_chunk;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_issue", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_opcode", mon_c[7:0], REQ_OP);
                    chk("sb_tag", mon_c[15:8], mon_e.tag);
                    chk("sb_chan", mon_c[23:16], mon_e.chan);
                    chk("sb_rsvd", mon_c[31:24], 8'd0);
                    chk("sb_ts", mon_c[63:32], rise_ts);
                end
                hs_q.push_back(tb_ts);
                if (echo_en) send_resp(RESP_OP, mon_c[15:8], rise_ts + 32'd40);
            end
        end
    end

    initial begin
        bif.rresp_valid     = 1'b0;
        bif.ipg_rresp_chunk = '0;
        forever begin
            tick();
            if (rsp_q.size() > 0 && rsp_q[0].due == tb_ts) begin
                bif.ipg_rresp_chunk = rsp_q[0].chunk;
                bif.rresp_valid     = 1'b1;
                void'(rsp_q.pop_front());
            end else begin
                if (rsp_q.size() > 0 && rsp_q[0].due < tb_ts) begin
                    chk("rsp_due_missed", rsp_q[0].due, tb_ts);
                    void'(rsp_q.pop_front());
                end
                bif.rresp_valid = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.req_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_valid_req", bif.valid_req, 1'b0);
        chk("rst_chunk", bif.ipg_req_chunk, 64'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sent", stat_sent, 32'd0);
        chk("rst_lat_max", stat_lat_max, 32'd0);

        // T1: three requests, interval 10
        interval = 16'd10; req_count = 32'd3; bif.req_ready = 1'b1;
        push_exp(3);
        en_ts = tb_ts;
        enable = 1'b1;
        for (int i = 0; i < 200 && !done; i++) tick();
        chk("t1_done", done, 1'b1);
        chk("t1_sent", stat_sent, 32'd3);
        chk("t1_busy", busy, 1'b0);
        chk("t1_hs_count", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            chk("t1_first_issue", hs_q[0] - en_ts, 32'(SD + 10 + 1));
            chk("t1_gap0", hs_q[1] - hs_q[0], 32'd11);
            chk("t1_gap1", hs_q[2] - hs_q[1], 32'd11);
        end
        enable = 1'b0;
        tick(); tick();
        chk("t1_done_clear", done, 1'b0);
        for (int i = 0; i < 300 && stat_timeout != 32'd3; i++) tick();
        chk("t1_timeouts", stat_timeout, 32'd3);

        // T2: back-pressure holds the chunk
        hs_q.delete();
        bif.req_ready = 1'b0; interval = 16'd2; req_count = 32'd1;
        push_exp(1);
        enable = 1'b1;
        for (int i = 0; i < 100 && !bif.valid_req; i++) tick();
        chk("t2_valid_seen", bif.valid_req, 1'b1);
        snap = bif.ipg_req_chunk;
        stable = 1'b1;
        repeat (5) begin
            tick();
            stable = stable && bif.valid_req && (bif.ipg_req_chunk == snap);
        end
        chk("t2_hold", stable, 1'b1);
        chk("t2_sent_before", stat_sent, 32'd3);
        bif.req_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) tick();
        chk("t2_done", done, 1'b1);
        chk("t2_sent_after", stat_sent, 32'd4);
        enable = 1'b0;
        for (int i = 0; i < 300 && stat_timeout != 32'd4; i++) tick();
        chk("t2_timeout", stat_timeout, 32'd4);

        // T3: echo every request 40 cycles later
        hs_q.delete();
        echo_en = 1'b1; interval = 16'd10; req_count = 32'd3;
        push_exp(3);
        enable = 1'b1;
        for (int i = 0; i < 200 && !done; i++) tick();
        chk("t3_done", done, 1'b1);
        for (int i = 0; i < 200 && stat_rcvd != 32'd3; i++) tick();
        chk("t3_rcvd", stat_rcvd, 32'd3);
        chk("t3_lat_last", stat_lat_last, 32'd40);
        chk("t3_lat_max", stat_lat_max, 32'd40);
        chk("t3_timeout", stat_timeout, 32'd4);
        chk("t3_unmatched", stat_unmatched, 32'd0);
        enable = 1'b0; echo_en = 1'b0;
        tick();

        // T5: free tag, out-of-range tag, wrong opcode
        send_resp(RESP_OP, 8'd1, tb_ts + 32'd2);
        repeat (5) tick();
        chk("t5_free_tag", stat_unmatched, 32'd1);
        send_resp(RESP_OP, 8'd9, tb_ts + 32'd2);
        repeat (5) tick();
        chk("t5_range_tag", stat_unmatched, 32'd2);
        send_resp(8'h00, 8'd0, tb_ts + 32'd2);
        repeat (5) tick();
        chk("t5_bad_op_unm", stat_unmatched, 32'd2);
        chk("t5_bad_op_rcvd", stat_rcvd, 32'd3);

        // T4: unlimited, no responses, interval 0 behaves as 1
        hs_q.delete();
        interval = 16'd0; req_count = 32'd0;
        push_exp(12);
        enable = 1'b1;
        for (int i = 0; i < 600 && hs_q.size() < 5; i++) tick();
        chk("t4_resumed", hs_q.size() >= 5, 1'b1);
        if (hs_q.size() >= 5) begin
            chk("t4_gap_min", hs_q[1] - hs_q[0], 32'd2);
            chk("t4_stall", (hs_q[4] - hs_q[3]) >= 32'(TO - 2), 1'b1);
        end
        chk("t4_timeout_inc", stat_timeout >= 32'd5, 1'b1);
        enable = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("t4_idle", busy, 1'b0);
        exp_q.delete();

        // T6a: response and timeout on the same entry in the same cycle
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        exp_q.delete(); hs_q.delete(); rsp_q.delete();
        m_tag = 8'd0; m_chan = 8'd0;
        chk("t6_rst_sent", stat_sent, 32'd0);
        chk("t6_rst_timeout", stat_timeout, 32'd0);
        chk("t6_rst_unm", stat_unmatched, 32'd0);
        chk("t6_rst_lat_max", stat_lat_max, 32'd0);
        interval = 16'd1; req_count = 32'd1; bif.req_ready = 1'b1;
        push_exp(1);
        enable = 1'b1;
        for (int i = 0; i < 100 && !done; i++) tick();
        chk("t6_done", done, 1'b1);
        enable = 1'b0;
        if (hs_q.size() == 1) begin
            ts0 = hs_q[0];
            t_coll = ts0 + 32'(TO);
            while (t_coll[TW-1:0] != '0) t_coll = t_coll + 32'd1;
            send_resp(RESP_OP, 8'd0, t_coll);
            for (int i = 0; i < 200 && stat_rcvd != 32'd1; i++) tick();
            tick();
            chk("t6_coll_rcvd", stat_rcvd, 32'd1);
            chk("t6_coll_timeout", stat_timeout, 32'd0);
            chk("t6_coll_lat", stat_lat_last, t_coll - ts0);
        end else begin
            chk("t6_hs_count", hs_q.size(), 1);
        end

        // T6b: reset while a request is presented
        bif.req_ready = 1'b0; req_count = 32'd1;
        enable = 1'b1;
        for (int i = 0; i < 100 && !bif.valid_req; i++) tick();
        chk("t6_valid_seen", bif.valid_req, 1'b1);
        rst = 1'b1; enable = 1'b0;
        tick();
        chk("t6_rst_valid", bif.valid_req, 1'b0);
        chk("t6_rst_chunk", bif.ipg_req_chunk, 64'd0);
        chk("t6_rst_sent2", stat_sent, 32'd0);
        chk("t6_rst_rcvd", stat_rcvd, 32'd0);
        chk("t6_rst_lat_last", stat_lat_last, 32'd0);
        chk("t6_rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
